// File: rtl/interval_capture.sv
// Interval capture: counts enabled cycles between start and stop, delivers the result via valid/ready.
// Optional sticky overflow output is enabled by defining INTERVAL_CAPTURE_OVF_EN.
module interval_capture #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             stop,
    input  logic             ready,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             busy,
`ifdef INTERVAL_CAPTURE_OVF_EN
    output logic             overflow,
`endif
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [WIDTH-1:0] CountMax = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] value_q, value_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        value_d = value_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // stop has priority over start so a coincident pair captures
                if (stop) begin
                    value_d = count_q;
                    state_d = StDone;
                end else if (start) begin
                    count_d = '0;
                end else if (enable && count_q != CountMax) begin
                    count_d = count_q + 1'b1;
                end
            end
            StDone: begin
                if (ready) begin
                    if (start) begin
                        count_d = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            value_q <= value_d;
        end
    end

`ifdef INTERVAL_CAPTURE_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if ((state_q == StIdle && start) ||
            (state_q == StRun && !stop && start) ||
            (state_q == StDone && ready && start)) begin
            ovf_d = 1'b0;
        end else if (state_q == StRun && !stop && enable && count_q == CountMax) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    assign value = value_q;
    assign count = count_q;
    assign valid = (state_q == StDone);
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_interval_capture.sv
// Scoreboard bench for interval_capture: expected captures are queued by the stimulus and
// popped by a monitor on each rising edge of valid.
module tb_interval_capture;

    logic       clk = 1'b0;
    logic       reset, enable, start, stop, ready;
    logic [4:0] value, count;
    logic       valid, busy;
`ifdef INTERVAL_CAPTURE_OVF_EN
    logic       overflow;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [4:0] exp_q[$];
    logic       valid_prev = 1'b0;

    always #5 clk = ~clk;

    interval_capture #(.WIDTH(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .start   (start),
        .stop    (stop),
        .ready   (ready),
        .value   (value),
        .valid   (valid),
        .busy    (busy),
`ifdef INTERVAL_CAPTURE_OVF_EN
        .overflow(overflow),
`endif
        .count   (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Inputs set before step() are sampled at the next rising edge; outputs read at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string name, input logic [4:0] exp_value);
        chk({name, "_value"}, 32'(value), 32'(exp_value));
        chk({name, "_count"}, 32'(count), 0);
        chk({name, "_valid"}, 32'(valid), 0);
        chk({name, "_busy"}, 32'(busy), 0);
    endtask

    // Monitor: each new valid assertion must match the oldest queued expectation.
    always @(negedge clk) begin
        if (valid === 1'b1 && !valid_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'(value), 32'hFFFF_FFFF);
            end else begin
                chk("capture_value", 32'(value), 32'(exp_q.pop_front()));
            end
        end
        valid_prev <= (valid === 1'b1);
    end

    initial begin
        reset = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; ready = 1'b0;
        // Reset dominates toggling inputs
        for (int i = 0; i < 2; i++) begin
            start = (i == 0); stop = (i == 1); enable = 1'b1;
            step();
            chk_idle("reset", 5'd0);
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; enable = 1'b0;
        step();
        chk_idle("post_reset", 5'd0);

        // Basic 7-tick interval
        start = 1'b1; step(); start = 1'b0;
        chk("start_count", 32'(count), 0);
        chk("start_busy", 32'(busy), 1);
        enable = 1'b1;
        repeat (7) step();
        enable = 1'b0; stop = 1'b1; exp_q.push_back(5'd7);
        step(); stop = 1'b0;
        chk("done_valid", 32'(valid), 1);
        chk("done_busy", 32'(busy), 1);
        ready = 1'b1; step(); ready = 1'b0;
        chk_idle_hold();

        // Gated enable: 4 of 10 cycles
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enable = (i % 3 == 0);
            step();
        end
        chk("gated_count", 32'(count), 4);
        enable = 1'b0; stop = 1'b1; exp_q.push_back(5'd4);
        step(); stop = 1'b0;
        ready = 1'b1; step(); ready = 1'b0;

        // Restart mid-run
        start = 1'b1; step(); start = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        chk("pre_restart_count", 32'(count), 3);
        start = 1'b1; step(); start = 1'b0;
        chk("restart_count", 32'(count), 0);
        repeat (5) step();
        enable = 1'b0; stop = 1'b1; exp_q.push_back(5'd5);
        step(); stop = 1'b0;
        ready = 1'b1; step(); ready = 1'b0;

        // Saturation
        start = 1'b1; step(); start = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
`ifdef INTERVAL_CAPTURE_OVF_EN
            if (i == 30) chk("ovf_before_32nd", 32'(overflow), 0);
            if (i == 31) chk("ovf_at_32nd", 32'(overflow), 1);
`endif
        end
        chk("sat_count", 32'(count), 31);
        enable = 1'b0; stop = 1'b1; exp_q.push_back(5'd31);
        step(); stop = 1'b0;
        ready = 1'b1; step(); ready = 1'b0;
`ifdef INTERVAL_CAPTURE_OVF_EN
        chk("ovf_hold_idle", 32'(overflow), 1);
`endif

        // Capture 3, then hold off ready while pulsing start
        start = 1'b1; step(); start = 1'b0;
`ifdef INTERVAL_CAPTURE_OVF_EN
        chk("ovf_cleared", 32'(overflow), 0);
`endif
        enable = 1'b1;
        repeat (3) step();
        enable = 1'b0; stop = 1'b1; exp_q.push_back(5'd3);
        step(); stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; enable = 1'b1; step();
            chk("stall_valid", 32'(valid), 1);
            chk("stall_value", 32'(value), 3);
            chk("stall_count", 32'(count), 3);
        end
        enable = 1'b0; ready = 1'b1; start = 1'b1; step();
        ready = 1'b0; start = 1'b0;
        chk("b2b_valid", 32'(valid), 0);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_count", 32'(count), 0);

        // Coincident start and stop in RUN with count=6
        enable = 1'b1;
        repeat (6) step();
        chk("pre_coinc_count", 32'(count), 6);
        start = 1'b1; stop = 1'b1; exp_q.push_back(5'd6);
        step(); start = 1'b0; stop = 1'b0; enable = 1'b0;
        chk("coinc_valid", 32'(valid), 1);
        chk("coinc_count", 32'(count), 6);
        ready = 1'b1; step(); ready = 1'b0;

        // Reset mid-run discards everything
        start = 1'b1; step(); start = 1'b0;
        enable = 1'b1;
        repeat (12) step();
        chk("pre_reset_count", 32'(count), 12);
        reset = 1'b1; stop = 1'b1; step(); reset = 1'b0; stop = 1'b0; enable = 1'b0;
        chk_idle("midrun_reset", 5'd0);
        step();
        chk("post_midrun_valid", 32'(valid), 0);

        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic chk_idle_hold();
        chk("ack_valid", 32'(valid), 0);
        chk("ack_busy", 32'(busy), 0);
        chk("ack_value_hold", 32'(value), 7);
    endtask

endmodule

// File: doc/interval_capture.md
Name: interval_capture

Overview:
- Measures the number of enabled clock cycles between a start pulse and a stop pulse.
- Delivers the result as a WIDTH-bit value with a valid/ready handshake.
- It is the producer side of the countdown timer's value/valid load interface: a captured interval can be replayed directly into the timer as a reload value.
- Three-state FSM (IDLE/RUN/DONE) plus a saturating up-counter.

Parameters:
WIDTH, 5, bit width of the counter and result.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  tick qualifier; counter advances only when high in RUN
start  input  1  begin/restart measurement (single-cycle pulse expected; level tolerated)
stop  input  1  end measurement and capture
ready  input  1  consumer accepts value when high while valid is high
value  output  WIDTH  captured interval, registered
valid  output  1  high while state is DONE
busy  output  1  high while state is RUN or DONE
count  output  WIDTH  live counter, registered

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, count=0, value=0, valid=0, busy=0.
  - Reset overrides all other inputs in the same cycle, including mid-RUN and mid-DONE; any pending result is discarded.
- valid = (state==DONE); busy = (state!=IDLE). Both are decoded from the registered state, so there are no combinational paths from inputs.
- IDLE:
  - start=1 -> count<=0, next RUN.
  - stop and ready are ignored.
  - start and stop in the same cycle: start wins.
  - count holds its last value.
- RUN:
  - stop=1 -> value<=count (the stop cycle's tick is not counted), count holds, next DONE.
  - else start=1 -> count<=0, stay RUN (restart).
  - else enable=1 and count!=2^WIDTH-1 -> count<=count+1.
  - else count holds; saturates at 2^WIDTH-1 (31 for WIDTH=5), no wrap.
  - start and stop in the same cycle: stop wins (capture, no restart).
- DONE:
  - value and count hold; enable is ignored.
  - ready=1 -> transfer completes, next IDLE. If start=1 in that same cycle, next RUN with count<=0 instead (back-to-back measurement).
  - ready=0 -> stay DONE, value stable, start ignored.
  - stop is ignored.
- Latency:
  - start sampled at edge N: count=0 and busy=1 after edge N.
  - First increment at the first edge after N with enable=1.
  - stop sampled at edge M: valid=1 and value valid after edge M.
  - ready sampled at edge K: valid=0 after edge K.
- value changes only on a RUN->DONE transition; it stays stable from then until the next capture, including while in IDLE.

Optional Feature:
- Macro: INTERVAL_CAPTURE_OVF_EN.
- Defined:
  - Adds output port overflow (1 bit), registered, reset 0.
  - Set when an enabled tick occurs in RUN while count==2^WIDTH-1 (the tick was lost).
  - Cleared on entry to RUN (start from IDLE, restart in RUN, or start with ready in DONE).
  - Holds through DONE and IDLE so the consumer can qualify value.
- Undefined: no overflow port; saturation is silent; all other behaviour is identical.

Test Plan:
- Assert reset 2 cycles with start/stop/enable toggling -> value=0, count=0, valid=0, busy=0 throughout and after release.
- start; enable=1 for 7 cycles; stop -> valid=1 the cycle after stop with value=7; ready=1 one cycle -> valid=0, busy=0, value stays 7.
- start; 10 RUN cycles with enable high on only 4; stop -> value=4. Then restart mid-run (start after 3 enabled ticks, then 5 more ticks, stop) -> value=5.
- start; enable=1 for 40 cycles; stop -> value=31, no wrap. With INTERVAL_CAPTURE_OVF_EN: overflow=1 from the 32nd tick, cleared after next start.
- Capture value=3; hold ready=0 for 3 cycles while pulsing start -> valid stays 1, value stays 3, state stays DONE. Then ready=1 with start=1 -> valid=0, busy=1, count=0 next cycle.
- start and stop in the same cycle while in RUN with count=6 -> value=6, DONE. Separately: reset mid-RUN with count=12 -> IDLE, count=0, no valid pulse.
